// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// baud timing helper also used by the transmitter.
package uart_pkg;

  localparam int unsigned data_bits = 8;
  localparam int unsigned stop_bits = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones so an
// idle-high line looks idle straight out of reset.
module uart_sync2 #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, centres sampling on the start bit and
// presents each byte on a valid/ready port with framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_hz    = 50_000_000,
  parameter int unsigned baud_rate = 115_200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [data_bits-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned bit_clks    = uart_pkg::clks_per_bit(clk_hz, baud_rate);
  localparam int unsigned half_bit    = bit_clks / 2;
  localparam int unsigned timer_width = (bit_clks <= 2) ? 1 : $clog2(bit_clks);
  localparam logic [timer_width-1:0] bit_last  = timer_width'(bit_clks - 1);
  localparam logic [timer_width-1:0] half_last = timer_width'(half_bit - 1);

  rx_state_t               state, state_next;
  logic [timer_width-1:0]  timer, timer_last;
  logic [2:0]              bit_index;
  logic [data_bits-1:0]    shreg;
  logic                    rxd_s;
  logic                    shift_en, stop_ok, stop_bad;

  uart_sync2 #(.width(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    timer_last = (state == START) ? half_last : bit_last;
    case (state)
      IDLE: if (!rxd_s) state_next = START;
      START: begin
        if (timer == half_last) state_next = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (timer == bit_last) begin
          shift_en = 1'b1;
          if (bit_index == 3'(data_bits - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (timer == bit_last) begin
          if (rxd_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: if (rxd_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Timer restarts on every state change so each phase measures from its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      bit_index <= '0;
      shreg     <= '0;
    end else begin
      if (state_next != state || timer == timer_last) timer <= '0;
      else                                            timer <= timer + 1'b1;

      if (state == START && state_next == DATA) bit_index <= '0;
      else if (shift_en)                        bit_index <= bit_index + 1'b1;

      if (shift_en) shreg <= {rxd_s, shreg[data_bits-1:1]};
    end
  end

  // A byte is accepted when the output slot is empty or drains this cycle;
  // otherwise it is dropped and the held byte stays untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_ok && rx_valid && !rx_ready;
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: clean frames, backpressure,
// glitch rejection, framing error with break, overrun and mid-frame reset.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q[$];
  int valid_cycles, fe_cnt, ov_cnt;
  int both_cnt = 0, long_cnt = 0, unstable_cnt = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(
    .clk_hz    (1_000_000),
    .baud_rate (100_000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_fe    = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if ((frame_err && prev_fe) || (overrun && prev_ov)) long_cnt++;
      if (prev_valid && !prev_ready && rx_data != prev_data) unstable_cnt++;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
      prev_fe    = frame_err;
      prev_ov    = overrun;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 10-bit frame, 10 clocks per bit; the stop level stays on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      idle(10);
    end
  endtask

  task automatic clear_stats();
    got_q.delete();
    valid_cycles = 0;
    fe_cnt       = 0;
    ov_cnt       = 0;
  endtask

  initial begin
    rxd      = 1'b1;
    rx_ready = 1'b0;
    rst_n    = 1'b0;
    clear_stats();
    idle(3);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_data", 32'(rx_data), 0);
    check("reset_ferr", 32'(frame_err), 0);
    check("reset_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    idle(5);

    // Clean byte with consumer always ready.
    clear_stats();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("a5_data", 32'(got_q[0]), 32'hA5);
    check("a5_valid_cycles", 32'(valid_cycles), 1);
    check("a5_flags", 32'(fe_cnt + ov_cnt), 0);

    // Backpressure: byte held until accepted.
    clear_stats();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    idle(110);
    check("3c_valid_held", 32'(rx_valid), 1);
    check("3c_data_held", 32'(rx_data), 32'h3C);
    check("3c_held_100", 32'(valid_cycles >= 100), 1);
    rx_ready = 1'b1;
    idle(1);
    check("3c_valid_clear", 32'(rx_valid), 0);
    check("3c_consumed", 32'(got_q.size()), 1);

    // Short low glitch is rejected at the half-bit check.
    clear_stats();
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(30);
    check("glitch_none", 32'(got_q.size() + fe_cnt + ov_cnt), 0);
    check("glitch_valid", 32'(rx_valid), 0);
    check("glitch_idle", 32'(dut.state), 32'(IDLE));

    // Bad stop bit followed by a held-low line, then a good frame.
    clear_stats();
    send_frame(8'h55, 1'b0);
    idle(50);
    check("ferr_pulses", 32'(fe_cnt), 1);
    check("ferr_no_valid", 32'(valid_cycles), 0);
    check("ferr_wait_high", 32'(dut.state), 32'(WAIT_HIGH));
    rxd = 1'b1;
    idle(10);
    send_frame(8'h0F, 1'b1);
    idle(20);
    check("0f_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("0f_data", 32'(got_q[0]), 32'h0F);
    check("0f_ferr_total", 32'(fe_cnt), 1);

    // Overrun: second byte dropped while the first is still held.
    clear_stats();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_pulses", 32'(ov_cnt), 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    // Accept the old byte in exactly the cycle the new stop bit is sampled.
    send_frame(8'h33, 1'b1);
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1 rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(10);
    check("swap_data", 32'(rx_data), 32'h44);
    check("swap_valid", 32'(rx_valid), 1);
    check("swap_no_ovr", 32'(ov_cnt), 1);
    check("swap_count", 32'(got_q.size()), 2);
    if (got_q.size() > 1) check("swap_old", 32'(got_q[1]), 32'h33);

    // Reset in the middle of a frame while a byte is pending.
    clear_stats();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (55) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("rst_mid_valid", 32'(rx_valid), 0);
        check("rst_mid_data", 32'(rx_data), 0);
        check("rst_mid_flags", 32'({frame_err, overrun}), 0);
        idle(3);
        rst_n = 1'b1;
      end
    join
    rx_ready = 1'b1;
    idle(10);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("81_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("81_data", 32'(got_q[0]), 32'h81);
    check("81_flags", 32'(fe_cnt + ov_cnt), 0);

    check("flags_exclusive", 32'(both_cnt), 0);
    check("flags_one_cycle", 32'(long_cnt), 0);
    check("data_stable", 32'(unstable_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1 frames: 8 data bits, LSB first, no parity, 1 stop bit. It is the receive-side counterpart to the team's UART transmitter and shares its clk_hz/baud_rate timing model. The block synchronises the asynchronous rxd line, finds each start bit, samples every bit at mid-period and presents completed bytes on a valid/ready output. It flags framing errors and overruns and sits between the pad and any byte-stream consumer.

Parameters:
- clk_hz, 50_000_000, system clock frequency in Hz.
- baud_rate, 115_200, UART bit rate.
- Derived, not overridable: clks_per_bit = clk_hz/baud_rate (integer division). half_bit = clks_per_bit/2. timer_width = 1 if clks_per_bit <= 2, else $clog2(clks_per_bit).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- rxd, input, 1: serial line, asynchronous to clk, idle high.
- rx_data, output, 8: received byte, stable while rx_valid=1.
- rx_valid, output, 1: byte available; held until accepted.
- rx_ready, input, 1: consumer accepts; transfer happens when rx_valid && rx_ready.
- frame_err, output, 1: one-cycle pulse when the stop bit samples 0.
- overrun, output, 1: one-cycle pulse when a byte is dropped because the output is still occupied.

Behaviour:
- Reset: rst_n=0 asynchronously clears state to IDLE and clears timer, bit index, shift register, rx_data=0x00, rx_valid=0, frame_err=0 and overrun=0. Both synchroniser flops reset to 1 (line idle). Reset mid-frame abandons the frame; no output is produced for it.
- Synchroniser: 2-flop chain gives rxd_s. All decisions use rxd_s, which adds 2 cycles of input latency.
- Bit timer: counts 0..limit-1, then wraps to 0. It is cleared on every state change.
- FSM, 3-bit encoding:
  - IDLE: when rxd_s=0, go to START with timer=0.
  - START: when timer==half_bit-1, sample rxd_s. If 0, go to DATA with bit_index=0 and timer=0. If 1, treat as a glitch and go to IDLE with no flags.
  - DATA: when timer==clks_per_bit-1, shift rxd_s into shreg[7] with a right shift, so the LSB arrives first. After bit_index==7, go to STOP; otherwise increment bit_index.
  - STOP: when timer==clks_per_bit-1, sample rxd_s.
    - If 1: deliver the byte (see below) and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1, then go to IDLE. This handles a break condition: no start is detected while the line is held low.
- Sampling point: each data bit and the stop bit are sampled about mid-bit, because the start bit is checked at half_bit.
- Delivery, in the cycle after the stop sample:
  - rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: the old byte is consumed, the new byte is loaded, and rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, keep the old rx_data and rx_valid.
- Handshake: rx_valid clears the cycle after rx_valid && rx_ready unless a new byte loads in that cycle. rx_data must not change while rx_valid=1 && !rx_ready.
- frame_err and overrun are never asserted together, and each lasts exactly one cycle.
- Reception continues regardless of rx_ready; no backpressure reaches the line.

Decomposition:
- Shared package uart_pkg holds:
  - rx state encodings: IDLE, START, DATA, STOP, WAIT_HIGH.
  - frame constants: data_bits=8, stop_bits=1.
  - a clks_per_bit(clk_hz, baud) function, also for use by the transmitter.
- One sub-module, uart_sync2: a parameterised 2-flop synchroniser with reset value 1 and async active-low reset, reusable for other async inputs.

Test Plan:
Bench uses clk_hz=1_000_000 and baud_rate=100_000, giving 10 clks/bit.
- Send 0xA5 with rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5; frame_err=0, overrun=0.
- Hold rx_ready=0, send 0x3C → rx_valid=1 and rx_data=0x3C held for 100+ cycles; raise rx_ready → rx_valid=0 next cycle.
- rxd low for 3 cycles, then high → no rx_valid, no flags; FSM back in IDLE.
- Frame 0x55 with stop bit forced 0, then line held low 50 cycles → one frame_err pulse, no rx_valid, no new start until rxd goes high; next frame 0x0F is received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11, one overrun pulse at the 0x22 stop sample. Repeat with rx_ready=1 at that cycle → rx_data=0x22, no overrun.
- Assert rst_n=0 at data bit 4 of 0xFF, release, send 0x81 → only 0x81 is delivered; all outputs were 0 during reset.
